seg_blink_ctrl: RTL

- Sequential controller directly upstream of the 7-bit 2:1 display mux; drives that mux's SEL.
- Mux wiring: D0 = digit code, D1 = blank pattern. sel=0 shows the digit, sel=1 blanks it.
- On a start pulse, blinks the digit a programmable number of times, then pulses done. Used for memory-game feedback (error/round-won flashes).

---
 rtl/seg_blink_ctrl_pkg.sv | 22 ++
 rtl/seg_blink_ctrl_phase_timer.sv | 40 ++++
 rtl/seg_blink_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg_blink_ctrl_pkg.sv
// Shared definitions for the digit blink controller: state encodings and the
// blank pattern that feeds D1 of the downstream 7-bit display mux.
// No logic or latency of its own; no flow control involved.
package seg_blink_ctrl_pkg;

    localparam int SEG_W = 7;

    // Driven onto D1 of the display mux; sel=1 routes it to the segments.
    localparam logic [SEG_W-1:0] BLANK_SEG = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    function automatic logic is_blinking(input state_e st);
        return (st == ST_ON) || (st == ST_OFF);
    endfunction

endpackage

// File: rtl/seg_blink_ctrl_phase_timer.sv
// Phase timer: counts enabled cycles and flags the last cycle of each phase.
// Latency: tc is high during the HALF_PERIOD-th enabled cycle after a clear.
// No backpressure; clear has priority over enable.
module seg_blink_ctrl_phase_timer #(
    parameter int HALF_PERIOD = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = enable && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            // Wrap at the terminal count so the counter never passes LAST.
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_blink_ctrl.sv
// Blink controller driving the display mux select; blinks the digit N times then pulses done.
// Latency: busy rises 1 cycle after start, lasts 2*N*HALF_PERIOD cycles, done follows.
// No backpressure: start is ignored while busy or finishing. SEG_BLINK_STOP_EN adds stop.
module seg_blink_ctrl
    import seg_blink_ctrl_pkg::*;
#(
    parameter int HALF_PERIOD = 25_000_000,
    parameter int CNT_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] blink_count,
`ifdef SEG_BLINK_STOP_EN
    input  logic             stop,
`endif
    output logic             sel,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tmr_clear;
    logic             tmr_enable;
    logic             tmr_tc;

    assign tmr_enable = is_blinking(state_q);

    seg_blink_ctrl_phase_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_phase_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .tc     (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tmr_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmr_clear = 1'b1;
                if (start) begin
                    if (blink_count != '0) begin
                        state_d     = ST_ON;
                        remaining_d = blink_count;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_ON: begin
                if (tmr_tc) begin
                    state_d = ST_OFF;
                end
            end
            ST_OFF: begin
                if (tmr_tc) begin
                    if (remaining_q == CNT_W'(1)) begin
                        state_d     = ST_FIN;
                        remaining_d = '0;
                    end else begin
                        state_d     = ST_ON;
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
            end
            ST_FIN: begin
                tmr_clear = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase

`ifdef SEG_BLINK_STOP_EN
        // Abort only mid-blink; the sequence still ends with a single done pulse.
        if (is_blinking(state_q) && stop) begin
            state_d     = ST_FIN;
            remaining_d = '0;
            tmr_clear   = 1'b1;
        end
`endif

        sel_d  = (state_d == ST_OFF);
        busy_d = is_blinking(state_d);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sel  = sel_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
